// File: rtl/out_channel.sv
// out_channel
//   Output buffer and result checker for a program engine. Words produced by
//   the engine are queued in a small circular buffer for the host to drain,
//   and each accepted word is compared, in order, against a static table of
//   expected words. Once the engine reports it has finished and the buffer
//   has emptied, the block reports finished/success until the next reset.
//
// Ports
//   clock           single clock, all state changes on its rising edge
//   reset           asynchronous, active-high reset
//   outValid        engine presents a word on outData
//   outData         word from the engine
//   outReady        buffer accepts a word this cycle
//   drainValid      buffer holds at least one word
//   drainData       oldest buffered word
//   drainReady      host consumes drainData this cycle
//   programFinished level: engine has reached its terminating state
//   expected        packed expected words, element k at [k*W +: W]
//   count           number of words currently buffered
//   finished        run complete
//   success         valid with finished, high when every check passed
module out_channel #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 4,
  parameter int NExpected          = 4
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    outValid,
  input  logic [MemoryElementWidth-1:0]           outData,
  output logic                                    outReady,
  output logic                                    drainValid,
  output logic [MemoryElementWidth-1:0]           drainData,
  input  logic                                    drainReady,
  input  logic                                    programFinished,
  input  logic [NExpected*MemoryElementWidth-1:0] expected,
  output logic [$clog2(NOut+1)-1:0]               count,
  output logic                                    finished,
  output logic                                    success
);

  localparam int PtrWidth   = (NOut > 1) ? $clog2(NOut) : 1;
  localparam int CountWidth = $clog2(NOut + 1);
  localparam int IdxWidth   = $clog2(NExpected + 1);

  localparam logic [PtrWidth-1:0]   LastPtr  = PtrWidth'(NOut - 1);
  localparam logic [CountWidth-1:0] Depth    = CountWidth'(NOut);
  localparam logic [IdxWidth-1:0]   IdxLimit = IdxWidth'(NExpected);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]                    state;
  logic [1:0]                    stateNext;
  logic [MemoryElementWidth-1:0] mem [NOut];
  logic [PtrWidth-1:0]           wp;
  logic [PtrWidth-1:0]           rp;
  logic [IdxWidth-1:0]           idx;
  logic                          error;
  logic                          errorNext;
  logic                          accept;
  logic                          consume;
  logic [MemoryElementWidth-1:0] expWord;

  // Handshakes come straight from registered state. outReady is low
  // whenever the buffer is full, even if the host drains in the same cycle,
  // so there is no combinational path from drainReady to outReady.
  assign outReady   = (state == RUN) && (count < Depth);
  assign drainValid = (count != '0);
  assign drainData  = mem[rp];
  assign accept     = outValid && outReady;
  assign consume    = drainValid && drainReady;

  // Select the expected word for the next accepted output. Constant slices
  // keep the select in range; once idx saturates the value is unused
  // because any further accept is an error on its own.
  always_comb begin
    expWord = '0;
    for (int k = 0; k < NExpected; k++) begin
      if (idx == IdxWidth'(k)) begin
        expWord = expected[k*MemoryElementWidth +: MemoryElementWidth];
      end
    end
  end

  // The error flag is sticky. Any word offered after the engine said it was
  // finished is discarded and counted as an error, as is an accept past the
  // end of the expected table or a value that differs from the table.
  always_comb begin
    errorNext = error;
    if (accept && ((idx == IdxLimit) || (outData != expWord))) begin
      errorNext = 1'b1;
    end
    if ((state != RUN) && outValid) begin
      errorNext = 1'b1;
    end
  end

  // RUN accepts words until programFinished; DRAIN waits for the host to
  // empty the buffer (leaving as the last word is consumed); DONE holds.
  always_comb begin
    stateNext = state;
    case (state)
      RUN: begin
        if (programFinished) begin
          stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if ((count == '0) || ((count == CountWidth'(1)) && consume)) begin
          stateNext = DONE;
        end
      end
      DONE:    stateNext = DONE;
      default: stateNext = RUN;
    endcase
  end

  // Buffer storage is deliberately left out of reset; stale contents are
  // never visible because drainValid is low whenever count is zero.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem[wp] <= outData;
    end
  end

  // Pointers, occupancy, checker and result registers. The result is
  // captured on the edge that enters DONE, using this edge's error update
  // so that a stray word in the final DRAIN cycle still fails the run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      idx      <= '0;
      error    <= 1'b0;
      state    <= RUN;
      finished <= 1'b0;
      success  <= 1'b0;
    end else begin
      if (accept) begin
        wp <= (wp == LastPtr) ? '0 : wp + PtrWidth'(1);
        if (idx != IdxLimit) begin
          idx <= idx + IdxWidth'(1);
        end
      end
      if (consume) begin
        rp <= (rp == LastPtr) ? '0 : rp + PtrWidth'(1);
      end
      case ({accept, consume})
        2'b10:   count <= count + CountWidth'(1);
        2'b01:   count <= count - CountWidth'(1);
        default: count <= count;
      endcase
      error <= errorNext;
      state <= stateNext;
      if ((state != DONE) && (stateNext == DONE)) begin
        finished <= 1'b1;
        success  <= !errorNext && (idx == IdxLimit);
      end
    end
  end

endmodule

// File: tb/tb_out_channel.sv
// tb_out_channel
//   Directed and randomized bench for out_channel. A queue-based reference
//   model tracks the buffered words, the checker index and the run phase;
//   every cycle the DUT outputs are compared against it before the clock
//   edge, and the model is advanced on the edge.
module tb_out_channel;

  localparam int W    = 12;
  localparam int NOUT = 4;
  localparam int NEXP = 4;

  logic              clock;
  logic              reset;
  logic              outValid;
  logic [W-1:0]      outData;
  logic              outReady;
  logic              drainValid;
  logic [W-1:0]      drainData;
  logic              drainReady;
  logic              programFinished;
  logic [NEXP*W-1:0] expected;
  logic [2:0]        count;
  logic              finished;
  logic              success;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state
  int q[$];
  int expArr[NEXP];
  int seq[$];
  int mIdx;
  bit mErr;
  bit mRun;
  bit mDone;
  bit mFin;
  bit mSucc;

  out_channel #(
    .MemoryElementWidth(W),
    .NOut(NOUT),
    .NExpected(NEXP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .outValid(outValid),
    .outData(outData),
    .outReady(outReady),
    .drainValid(drainValid),
    .drainData(drainData),
    .drainReady(drainReady),
    .programFinished(programFinished),
    .expected(expected),
    .count(count),
    .finished(finished),
    .success(success)
  );

  // Free-running clock, 10 time units per period
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One comparison: counts it, and reports a failure with its tag
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with the model's view of the current cycle
  task automatic checkAll();
    checkOutput("outReady", outReady, 32'(mRun && (q.size() < NOUT)));
    checkOutput("drainValid", drainValid, 32'(q.size() != 0));
    if (q.size() != 0) checkOutput("drainData", drainData, q[0]);
    checkOutput("count", count, q.size());
    checkOutput("finished", finished, 32'(mFin));
    checkOutput("success", success, 32'(mSucc));
  endtask

  // Drive one cycle of inputs at the falling edge, check outputs, then
  // advance the model on the rising edge. Ends on the next falling edge.
  task automatic applyStimulus(input bit ov, input int od, input bit dr, input bit pf);
    int  oldSize;
    bit  acc;
    bit  con;
    bit  wasDraining;
    outValid        = ov;
    outData         = od[W-1:0];
    drainReady      = dr;
    programFinished = pf;
    #1;
    checkAll();
    @(posedge clock);
    oldSize     = q.size();
    acc         = ov && mRun && (oldSize < NOUT);
    con         = (oldSize != 0) && dr;
    wasDraining = !mRun && !mDone;
    if (con) void'(q.pop_front());
    if (acc) begin
      q.push_back(od & ((1 << W) - 1));
      if (mIdx == NEXP || (od & ((1 << W) - 1)) != expArr[mIdx]) mErr = 1'b1;
      if (mIdx < NEXP) mIdx++;
    end
    if (!mRun && ov) mErr = 1'b1;
    if (mRun && pf) begin
      mRun = 1'b0;
    end else if (wasDraining && (oldSize == 0 || (oldSize == 1 && con))) begin
      mDone = 1'b1;
      mFin  = 1'b1;
      mSucc = !mErr && (mIdx == NEXP);
    end
    @(negedge clock);
  endtask

  // Raise reset after a delay (so it can land between edges), confirm the
  // asynchronous reset values before any edge, then release on the next
  // falling edge. expArr is loaded into the static expected port here.
  task automatic doReset(input int delay);
    #delay;
    reset           = 1'b1;
    outValid        = 1'b0;
    outData         = '0;
    drainReady      = 1'b0;
    programFinished = 1'b0;
    for (int k = 0; k < NEXP; k++) expected[k*W +: W] = expArr[k][W-1:0];
    #1;
    checkOutput("rstOutReady", outReady, 1);
    checkOutput("rstDrainValid", drainValid, 0);
    checkOutput("rstCount", count, 0);
    checkOutput("rstFinished", finished, 0);
    checkOutput("rstSuccess", success, 0);
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    mIdx  = 0;
    mErr  = 1'b0;
    mRun  = 1'b1;
    mDone = 1'b0;
    mFin  = 1'b0;
    mSucc = 1'b0;
  endtask

  // Write the words in seq with the host always draining, finish the
  // program, optionally push a stray word during DRAIN, then let it settle.
  task automatic runSeq(input bit strayWord, input bit wantSuccess);
    doReset(0);
    foreach (seq[i]) applyStimulus(1'b1, seq[i], 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
    if (strayWord) applyStimulus(1'b1, 3, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("runFinished", finished, 1);
    checkOutput("runSuccess", success, 32'(wantSuccess));
  endtask

  // Directed scenarios followed by randomized runs
  initial begin
    reset           = 1'b1;
    outValid        = 1'b0;
    outData         = '0;
    drainReady      = 1'b0;
    programFinished = 1'b0;
    expected        = '0;
    expArr          = '{99, 0, 1, 2};
    @(negedge clock);

    $display("[TB] nominal run");
    seq = '{99, 0, 1, 2};
    runSeq(1'b0, 1'b1);

    $display("[TB] full buffer");
    doReset(0);
    foreach (seq[i]) applyStimulus(1'b1, seq[i], 1'b0, 1'b0);
    checkOutput("fullCount", count, 4);
    checkOutput("fullReady", outReady, 0);
    applyStimulus(1'b1, 5, 1'b0, 1'b0);
    applyStimulus(1'b1, 5, 1'b1, 1'b0);
    checkOutput("afterDrainCount", count, 3);
    checkOutput("afterDrainReady", outReady, 1);
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
    repeat (5) applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("fullRunSuccess", success, 1);

    $display("[TB] accept and consume across pointer wrap");
    doReset(0);
    applyStimulus(1'b1, 99, 1'b0, 1'b0);
    applyStimulus(1'b1, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1, 1'b1, 1'b0);
    applyStimulus(1'b1, 2, 1'b1, 1'b0);
    checkOutput("wrapCount", count, 2);
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("wrapSuccess", success, 1);

    $display("[TB] failing runs");
    seq = '{99, 0, 7, 2};
    runSeq(1'b0, 1'b0);
    seq = '{99, 0, 1};
    runSeq(1'b0, 1'b0);
    seq = '{99, 0, 1, 2};
    runSeq(1'b1, 1'b0);

    $display("[TB] asynchronous reset during DRAIN");
    doReset(0);
    applyStimulus(1'b1, 99, 1'b0, 1'b0);
    applyStimulus(1'b1, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("drainCount", count, 2);
    doReset(3);
    runSeq(1'b0, 1'b1);

    $display("[TB] randomized runs");
    for (int r = 0; r < 20; r++) begin
      bit pfLevel;
      for (int k = 0; k < NEXP; k++) expArr[k] = int'($urandom_range(0, (1 << W) - 1));
      doReset(0);
      pfLevel = 1'b0;
      for (int c = 0; c < 60 && !mDone; c++) begin
        bit ov;
        bit dr;
        int od;
        if (c >= 20 || (c >= 3 && $urandom_range(0, 5) == 0)) pfLevel = 1'b1;
        ov = mRun ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
        od = (mIdx < NEXP && $urandom_range(0, 5) != 0) ? expArr[mIdx]
                                                        : int'($urandom_range(0, (1 << W) - 1));
        dr = (c > 40) ? 1'b1 : bit'($urandom_range(0, 1));
        applyStimulus(ov, od, dr, pfLevel);
      end
      checkOutput("randFinished", finished, 1);
      applyStimulus(1'b0, 0, 1'b1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
